// File: rtl/tff_counter_ctrl.sv
// Sequencer for an external bank of WIDTH toggle flip-flops used as a counter.
// Loads a start value through t_out, then counts up or down at a prescaled rate.
module tff_counter_ctrl #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  dir,
   input  logic                  reload_en,
   input  logic [WIDTH-1:0]      load_val,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [WIDTH-1:0]      q_in,
   output logic [WIDTH-1:0]      t_out,
   output logic                  busy,
   output logic                  tc_pulse,
   output logic                  done
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic [WIDTH-1:0]      ld_q, ld_d;
   logic                  dir_q, dir_d;
   logic                  rel_q, rel_d;
   logic                  busy_q, done_q;
   logic                  tick, term;

   // Ripple-carry/borrow toggle pattern: bit i flips when all lower bits are 1 (up) or 0 (down).
   function automatic logic [WIDTH-1:0] step_vec(input logic [WIDTH-1:0] q, input logic up);
      logic [WIDTH-1:0] v;
      logic             run;
      run = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         v[i] = run;
         run  = run & (up ? q[i] : ~q[i]);
      end
      return v;
   endfunction

   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      pre_d     = pre_q;
      ld_d      = ld_q;
      dir_d     = dir_q;
      rel_d     = rel_q;
      t_out     = '0;
      tc_pulse  = 1'b0;
      tick      = (pre_cnt_q == pre_q);
      term      = dir_q ? (&q_in) : ~(|q_in);

      if (stop) begin
         state_d = S_IDLE;
      end else if (start) begin
         state_d = S_LOAD;
         pre_d   = prescale;
         ld_d    = load_val;
         dir_d   = dir;
         rel_d   = reload_en;
      end else begin
         case (state_q)
            S_LOAD: begin
               t_out     = q_in ^ ld_q;
               pre_cnt_d = '0;
               state_d   = S_RUN;
            end
            S_RUN: begin
               pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
               if (tick) begin
                  if (term) begin
                     tc_pulse = 1'b1;
                     // Reload jumps straight to ld_q instead of wrapping through zero/all-ones.
                     if (rel_q) t_out = q_in ^ ld_q;
                     else       state_d = S_DONE;
                  end else begin
                     t_out = step_vec(q_in, dir_q);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pre_cnt_q <= '0;
         pre_q     <= '0;
         ld_q      <= '0;
         dir_q     <= 1'b0;
         rel_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         pre_q     <= pre_d;
         ld_q      <= ld_d;
         dir_q     <= dir_d;
         rel_q     <= rel_d;
         busy_q    <= (state_d == S_LOAD) || (state_d == S_RUN);
         done_q    <= (state_d == S_DONE);
      end
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Bench for tff_counter_ctrl driving an 8-bit T-FF bank; expectations are queued per cycle
// and a monitor compares them at the falling edge.
module tb_tff_counter_ctrl;

   logic       clk, reset, start, stop, dir, reload_en;
   logic [7:0] load_val, q, t_out;
   logic [3:0] prescale;
   logic       busy, tc_pulse, done;
   logic       reset_n;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   bit         stim_done = 0;

   typedef struct {
      int         cyc;
      string      name;
      logic       cq;
      logic [7:0] q;
      logic       ct;
      logic [7:0] t;
      logic       b;
      logic       d;
      logic       tc;
   } exp_t;

   exp_t sb[$];

   tff_counter_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
      .reload_en(reload_en), .load_val(load_val), .prescale(prescale),
      .q_in(q), .t_out(t_out), .busy(busy), .tc_pulse(tc_pulse), .done(done)
   );

   assign reset_n = ~reset;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q <= '0;
      else          q <= q ^ t_out;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic nxt();
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic cmd_start(input logic d, input logic r, input logic [7:0] ld, input logic [3:0] p);
      start = 1'b1; dir = d; reload_en = r; load_val = ld; prescale = p;
   endtask

   task automatic ex(input string n, input logic cq, input logic [7:0] eq, input logic ct,
                     input logic [7:0] et, input logic b, input logic d, input logic tc);
      exp_t e;
      e.cyc = cyc; e.name = n; e.cq = cq; e.q = eq; e.ct = ct; e.t = et;
      e.b = b; e.d = d; e.tc = tc;
      sb.push_back(e);
   endtask

   // Stimulus
   initial begin
      logic [7:0] dq [3];
      logic [7:0] dt [3];
      dq[0] = 8'h03; dq[1] = 8'h02; dq[2] = 8'h01;
      dt[0] = 8'h01; dt[1] = 8'h03; dt[2] = 8'h01;
      reset = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; reload_en = 1'b0;
      load_val = '0; prescale = '0;

      nxt(); ex("rst", 1, 8'h00, 1, 8'h00, 0, 0, 0);
      nxt(); reset = 1'b0; ex("idle", 1, 8'h00, 1, 8'h00, 0, 0, 0);

      // up one-shot from FC
      nxt(); cmd_start(1, 0, 8'hFC, 0); ex("t1_start", 1, 8'h00, 1, 8'h00, 0, 0, 0);
      nxt(); ex("t1_load", 1, 8'h00, 1, 8'hFC, 1, 0, 0);
      nxt(); ex("t1_fc",   1, 8'hFC, 1, 8'h01, 1, 0, 0);
      nxt(); ex("t1_fd",   1, 8'hFD, 1, 8'h03, 1, 0, 0);
      nxt(); ex("t1_fe",   1, 8'hFE, 1, 8'h01, 1, 0, 0);
      nxt(); ex("t1_ff",   1, 8'hFF, 1, 8'h00, 1, 0, 1);
      nxt(); ex("t1_done", 1, 8'hFF, 1, 8'h00, 0, 1, 0);

      // up with reload from FD
      nxt(); cmd_start(1, 1, 8'hFD, 0); ex("t1_hold", 1, 8'hFF, 1, 8'h00, 0, 1, 0);
      nxt(); ex("t2_load", 1, 8'hFF, 1, 8'h02, 1, 0, 0);
      for (int k = 0; k < 2; k++) begin
         nxt(); ex("t2_fd", 1, 8'hFD, 1, 8'h03, 1, 0, 0);
         nxt(); ex("t2_fe", 1, 8'hFE, 1, 8'h01, 1, 0, 0);
         nxt(); ex("t2_ff", 1, 8'hFF, 1, 8'h02, 1, 0, 1);
      end

      // down, prescale 2, from 03 (restarted out of RUN)
      nxt(); cmd_start(0, 0, 8'h03, 2); ex("t3_start", 1, 8'hFD, 0, 8'h00, 1, 0, 0);
      nxt(); ex("t3_load", 1, 8'hFD, 1, 8'hFE, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         nxt(); ex("t3_wait0", 1, dq[k], 1, 8'h00, 1, 0, 0);
         nxt(); ex("t3_wait1", 1, dq[k], 1, 8'h00, 1, 0, 0);
         nxt(); ex("t3_tick",  1, dq[k], 1, dt[k], 1, 0, 0);
      end
      nxt(); ex("t3_00a", 1, 8'h00, 1, 8'h00, 1, 0, 0);
      nxt(); ex("t3_00b", 1, 8'h00, 1, 8'h00, 1, 0, 0);
      nxt(); ex("t3_tc",  1, 8'h00, 1, 8'h00, 1, 0, 1);

      // abort at 05, then start+stop together
      nxt(); cmd_start(1, 0, 8'h04, 0); ex("t3_done", 1, 8'h00, 1, 8'h00, 0, 1, 0);
      nxt(); ex("t4_load", 1, 8'h00, 1, 8'h04, 1, 0, 0);
      nxt(); ex("t4_04",   1, 8'h04, 1, 8'h01, 1, 0, 0);
      nxt(); stop = 1'b1; ex("t4_stop", 1, 8'h05, 1, 8'h00, 1, 0, 0);
      nxt(); cmd_start(1, 0, 8'h20, 0); stop = 1'b1; ex("t4_idle", 1, 8'h05, 1, 8'h00, 0, 0, 0);
      nxt(); ex("t4_both",  1, 8'h05, 1, 8'h00, 0, 0, 0);
      nxt(); ex("t4_idle2", 1, 8'h05, 1, 8'h00, 0, 0, 0);

      // reset mid-RUN on a tick cycle
      nxt(); cmd_start(1, 0, 8'h10, 1); ex("t5_start", 1, 8'h05, 1, 8'h00, 0, 0, 0);
      nxt(); ex("t5_load", 1, 8'h05, 1, 8'h15, 1, 0, 0);
      nxt(); ex("t5_wait", 1, 8'h10, 1, 8'h00, 1, 0, 0);
      nxt(); reset = 1'b1; ex("t5_rst", 1, 8'h00, 1, 8'h00, 0, 0, 0);
      nxt(); reset = 1'b0; ex("t5_after", 1, 8'h00, 1, 8'h00, 0, 0, 0);

      // restart during RUN with new config
      nxt(); cmd_start(1, 0, 8'h40, 0); ex("t6_start", 1, 8'h00, 1, 8'h00, 0, 0, 0);
      nxt(); ex("t6_load", 1, 8'h00, 1, 8'h40, 1, 0, 0);
      nxt(); ex("t6_40",   1, 8'h40, 1, 8'h01, 1, 0, 0);
      nxt(); cmd_start(0, 0, 8'h80, 1); ex("t6_restart", 1, 8'h41, 0, 8'h00, 1, 0, 0);
      nxt(); ex("t6_load2",   0, 8'h00, 0, 8'h00, 1, 0, 0);
      nxt(); ex("t6_80",      1, 8'h80, 1, 8'h00, 1, 0, 0);
      nxt(); ex("t6_80_tick", 1, 8'h80, 1, 8'hFF, 1, 0, 0);
      nxt(); ex("t6_7f",      1, 8'h7F, 1, 8'h00, 1, 0, 0);
      nxt(); ex("t6_7f_tick", 1, 8'h7F, 1, 8'h01, 1, 0, 0);
      nxt(); ex("t6_7e",      1, 8'h7E, 1, 8'h00, 1, 0, 0);
      nxt();
      stim_done = 1'b1;
   end

   // Monitor
   initial begin
      exp_t e;
      logic bad;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            bad = (e.cq && (q !== e.q)) || (e.ct && (t_out !== e.t)) ||
                  (busy !== e.b) || (done !== e.d) || (tc_pulse !== e.tc);
            checks++;
            if (bad) begin
               errors++;
               $display("FAIL %s cyc=%0d got q=%h t=%h busy=%b done=%b tc=%b want q=%h t=%h busy=%b done=%b tc=%b",
                        e.name, cyc, q, t_out, busy, done, tc_pulse, e.q, e.t, e.b, e.d, e.tc);
            end
         end
         if (stim_done) break;
         if (cyc > 2000) begin
            checks++;
            errors++;
            $display("FAIL watchdog cyc=%0d got stimulus unfinished want finished", cyc);
            break;
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL %s got unchecked want checked", e.name);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
